// File: rtl/tx_fifo.sv
// Parametrised synchronous circular transmit FIFO with first-word-fall-through head,
// exact occupancy count, sticky overflow/underflow flags and a synchronous flush.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] datain,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             clear,
    output logic [WIDTH-1:0] dataout,
    output logic             tbnfout,
    output logic             tbneout,
    output logic [CW-1:0]    countout,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_ok;
    logic             push_ok;
    logic             is_empty;
    logic             is_full;

    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == CW'(DEPTH));
        pop_ok   = rd_en && !is_empty;
        // a push into a full queue only fits when the head leaves in the same cycle
        push_ok  = wr_en && (!is_full || pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && !push_ok) overflow  <= 1'b1;
            if (rd_en && is_empty) underflow <= 1'b1;
        end
    end

    // storage is deliberately left out of reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (!reset && !clear && push_ok) mem[wr_ptr] <= datain;
    end

    always_comb begin
        dataout  = is_empty ? '0 : mem[rd_ptr];
        tbnfout  = !is_full;
        tbneout  = !is_empty;
        countout = count;
    end

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_tx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] datain;
    logic             wr_en;
    logic             rd_en;
    logic             clear;
    logic [WIDTH-1:0] dataout;
    logic             tbnfout;
    logic             tbneout;
    logic [CW-1:0]    countout;
    logic             overflow;
    logic             underflow;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic             model_ovf;
    logic             model_unf;

    tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .datain    (datain),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .clear     (clear),
        .dataout   (dataout),
        .tbnfout   (tbnfout),
        .tbneout   (tbneout),
        .countout  (countout),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: a bounded queue of DEPTH words plus two sticky flags.
    function automatic void model_step(input logic rs, input logic cl, input logic w,
                                       input logic r, input logic [WIDTH-1:0] d);
        bit pop, push;
        if (rs || cl) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
            pop  = r && (model_q.size() > 0);
            push = w && ((model_q.size() < DEPTH) || pop);
            if (r && model_q.size() == 0) model_unf = 1'b1;
            if (w && !push) model_ovf = 1'b1;
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(d);
        end
    endfunction

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_head;
        exp_head = (model_q.size() > 0) ? model_q[0] : '0;
        chk({tag, ".dataout"},   32'(dataout),   32'(exp_head));
        chk({tag, ".countout"},  32'(countout),  32'(model_q.size()));
        chk({tag, ".tbnfout"},   32'(tbnfout),   32'(model_q.size() != DEPTH));
        chk({tag, ".tbneout"},   32'(tbneout),   32'(model_q.size() != 0));
        chk({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(model_unf));
    endtask

    task automatic cycle(input logic rs, input logic cl, input logic w, input logic r,
                         input logic [WIDTH-1:0] d, input string tag);
        reset  = rs;
        clear  = cl;
        wr_en  = w;
        rd_en  = r;
        datain = d;
        @(posedge clk);
        model_step(rs, cl, w, r, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             rs, cl, w, r;
        int unsigned      wbias;
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; datain = '0;

        cycle(1, 0, 0, 0, 8'h00, "reset");
        chk("reset.count0", 32'(countout), 32'd0);
        chk("reset.nf1",    32'(tbnfout),  32'd1);

        for (int i = 1; i <= DEPTH; i++) cycle(0, 0, 1, 0, 8'(i), "fill");
        chk("fill.head", 32'(dataout), 32'h01);
        chk("fill.nf0",  32'(tbnfout), 32'd0);

        cycle(0, 0, 1, 0, 8'h55, "push_full");
        chk("push_full.ovf", 32'(overflow), 32'd1);

        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 8'h00, "drain");
        chk("drain.empty", 32'(tbneout),  32'd0);
        chk("drain.ovf",   32'(overflow), 32'd1);

        cycle(1, 0, 0, 0, 8'h00, "reset2");
        for (int i = 1; i <= DEPTH; i++) cycle(0, 0, 1, 0, 8'(i), "fill2");
        cycle(0, 0, 1, 1, 8'hAA, "both_full");
        chk("both_full.head", 32'(dataout),  32'h02);
        chk("both_full.ovf",  32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 0, 0, 1, 8'h00, "drain2");
        chk("drain2.last", 32'(dataout), 32'hAA);
        cycle(0, 0, 0, 1, 8'h00, "drain2_end");

        cycle(0, 0, 0, 1, 8'h00, "pop_empty");
        chk("pop_empty.unf", 32'(underflow), 32'd1);
        cycle(0, 0, 1, 1, 8'h33, "both_empty");
        chk("both_empty.head", 32'(dataout),  32'h33);
        chk("both_empty.cnt",  32'(countout), 32'd1);
        cycle(0, 0, 0, 1, 8'h00, "both_empty_pop");

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) cycle(0, 0, 1, 0, 8'(8'h40 + i), "wrap_push");
            else            cycle(0, 0, 0, 1, 8'h00, "wrap_pop");
        end

        for (int i = 1; i <= DEPTH; i++) cycle(0, 0, 1, 0, 8'(i), "fill3");
        cycle(0, 0, 1, 0, 8'h99, "ovf3");
        for (int i = 0; i < DEPTH - 5; i++) cycle(0, 0, 0, 1, 8'h00, "to5");
        chk("to5.cnt", 32'(countout), 32'd5);
        cycle(0, 1, 1, 0, 8'hEE, "clear");
        chk("clear.cnt", 32'(countout), 32'd0);
        chk("clear.ovf", 32'(overflow), 32'd0);
        cycle(0, 0, 1, 0, 8'h77, "after_clear");
        chk("after_clear.head", 32'(dataout), 32'h77);

        for (int i = 0; i < 3000; i++) begin
            wbias = ((i / 200) % 2 == 0) ? 3 : 1;
            rs = ($urandom % 300) == 0;
            cl = ($urandom % 150) == 0;
            w  = ($urandom % 4) < wbias;
            r  = ($urandom % 4) >= wbias;
            d  = 8'($urandom);
            cycle(rs, cl, w, r, d, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
